// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: PC and IF/ID enables, bubble insertion,
// HI/LO multi-cycle start/busy tracking, stall watchdog and stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_LAT  = 5,
  parameter int unsigned DIV_LAT   = 10,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned MAX_STALL = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isPause,
  input  logic        ID_isMD,
  input  logic        ID_isDiv,
  input  logic        ID_isHiLo,
  input  logic        ID_redirect,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        IF_ID_clr,
  output logic        ID_EX_clr,
  output logic        md_start,
  output logic        md_busy,
  output logic        stall_err,
  output logic [31:0] stall_cnt
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  typedef enum logic {IDLE, MD_BUSY} md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_nxt;
  logic [RUN_W-1:0] run;
  logic             stall;

  assign md_busy = (state == MD_BUSY);

  always_comb begin
    stall     = isPause | (md_busy & (ID_isMD | ID_isHiLo));
    PC_en     = ~stall;
    IF_ID_en  = ~stall;
    ID_EX_clr = stall;
    IF_ID_clr = ID_redirect & ~stall;
    md_start  = ID_isMD & ~stall;
  end

  always_comb begin
    md_cnt_nxt = md_cnt;
    if (md_start)
      md_cnt_nxt = ID_isDiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (md_cnt != '0)
      md_cnt_nxt = md_cnt - CNT_W'(1);
  end

  // State mirrors md_cnt != 0 but is taken from the next count so md_busy stays a flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      md_cnt    <= '0;
      run       <= '0;
      stall_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      md_cnt <= md_cnt_nxt;
      state  <= (md_cnt_nxt != '0) ? MD_BUSY : IDLE;
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
        if (run != RUN_W'(MAX_STALL))
          run <= run + RUN_W'(1);
        // Error lands on the edge that brings run to MAX_STALL.
        if (run >= RUN_W'(MAX_STALL - 1))
          stall_err <= 1'b1;
      end else begin
        run <= '0;
      end
    end
  end

endmodule
